// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencing on a DATA_W-bit
// register file, with host preload ports and a result latch captured on HALT.
module mips_multicycle_core #(
    parameter int DATA_W     = 8,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 16,
    parameter int OUT_REG    = 2,
    parameter int START_PC   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [31:0]                   imem_wdata,
    input  logic                          dmem_we,
    input  logic [$clog2(DMEM_DEPTH)-1:0] dmem_addr,
    input  logic [DATA_W-1:0]             dmem_wdata,
    output logic [DATA_W-1:0]             dmem_rdata,
    output logic                          busy,
    output logic                          done,
    output logic [DATA_W-1:0]             result,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc,
    output logic                          illegal,
    output logic [15:0]                   instr_count
);
    localparam int PW = $clog2(IMEM_DEPTH);
    localparam int AW = $clog2(DMEM_DEPTH);
    localparam logic [PW-1:0] PC_ONE   = PW'(1);
    localparam logic [PW-1:0] PC_MAX   = PW'(IMEM_DEPTH - 1);
    localparam logic [PW-1:0] PC_START = PW'(START_PC);
    localparam logic [4:0]    OUT_IDX  = 5'(OUT_REG);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        C_ADDU, C_SLT, C_JR, C_J, C_JAL, C_BEQ, C_BNE, C_ADDIU, C_LW, C_SW, C_HALT, C_ILL
    } class_e;

    state_e            r_state, w_next;
    class_e            w_cls;
    logic [31:0]       r_imem [IMEM_DEPTH];
    logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];
    logic [DATA_W-1:0] r_regs [32];
    logic [31:0]       r_ir;
    logic [PW-1:0]     r_pc;
    logic [DATA_W-1:0] r_a, r_b, r_alu, r_mdr, r_result;
    logic              r_wrap, r_illegal;
    logic [15:0]       r_count;

    logic [31:0]       w_sext, w_a32, w_alu32, w_pc1_32;
    logic [DATA_W-1:0] w_imm, w_wdata;
    logic [PW-1:0]     w_pc1, w_br_tgt, w_pc_next;
    logic [AW-1:0]     w_daddr;
    logic [4:0]        w_wa;
    logic              w_taken, w_fall, w_wrap_now, w_exec_last, w_retire, w_start_ok;
    logic              w_unused;

    assign w_sext     = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_imm      = w_sext[DATA_W-1:0];
    assign w_a32      = 32'(r_a);
    assign w_alu32    = 32'(r_alu);
    assign w_daddr    = w_alu32[AW-1:0];
    assign w_pc1      = r_pc + PC_ONE;
    assign w_pc1_32   = 32'(w_pc1);
    assign w_br_tgt   = w_pc1 + w_sext[PW-1:0];
    assign w_unused   = ^{r_ir, w_sext, w_a32, w_alu32, w_pc1_32};

    always_comb begin
        w_cls = C_ILL;
        case (r_ir[31:26])
            6'd0: begin
                case (r_ir[5:0])
                    6'd33:   w_cls = C_ADDU;
                    6'd42:   w_cls = C_SLT;
                    6'd8:    w_cls = C_JR;
                    default: w_cls = C_ILL;
                endcase
            end
            6'd2:    w_cls = C_J;
            6'd3:    w_cls = C_JAL;
            6'd4:    w_cls = C_BEQ;
            6'd5:    w_cls = C_BNE;
            6'd9:    w_cls = C_ADDIU;
            6'd35:   w_cls = C_LW;
            6'd43:   w_cls = C_SW;
            6'd63:   w_cls = C_HALT;
            default: w_cls = C_ILL;
        endcase
    end

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_taken     = 1'b0;
        w_fall      = 1'b1;
        w_pc_next   = w_pc1;
        w_wa        = 5'd0;
        w_exec_last = 1'b0;
        case (w_cls)
            C_ADDU, C_SLT:  w_wa = r_ir[15:11];
            C_ADDIU, C_LW:  w_wa = r_ir[20:16];
            C_JAL: begin
                w_wa      = 5'd31;
                w_fall    = 1'b0;
                w_pc_next = r_ir[PW-1:0];
            end
            C_J: begin
                w_fall      = 1'b0;
                w_pc_next   = r_ir[PW-1:0];
                w_exec_last = 1'b1;
            end
            C_JR: begin
                w_fall      = 1'b0;
                w_pc_next   = w_a32[PW-1:0];
                w_exec_last = 1'b1;
            end
            C_BEQ, C_BNE: begin
                w_taken     = (r_a == r_b) ^ (w_cls == C_BNE);
                w_fall      = !w_taken;
                w_exec_last = 1'b1;
                if (w_taken) w_pc_next = w_br_tgt;
            end
            C_ILL:   w_exec_last = 1'b1;
            default: ;
        endcase
    end

    // Fall-through off the last instruction word ends the run instead of wrapping.
    assign w_wrap_now = w_fall && (r_pc == PC_MAX);
    assign w_wdata    = (w_cls == C_LW) ? r_mdr : r_alu;
    assign w_start_ok = start && (r_state == S_IDLE || r_state == S_HALT);
    assign w_retire   = (r_state == S_EXEC && w_exec_last) ||
                        (r_state == S_MEM && w_cls == C_SW) || (r_state == S_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_HALT: if (start) w_next = S_FETCH;
            S_FETCH:        w_next = S_DECODE;
            S_DECODE:       w_next = (w_cls == C_HALT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (w_exec_last)                      w_next = w_wrap_now ? S_HALT : S_FETCH;
                else if (w_cls == C_LW || w_cls == C_SW) w_next = S_MEM;
                else                                  w_next = S_WB;
            end
            S_MEM:   w_next = (w_cls == C_LW) ? S_WB : (r_wrap ? S_HALT : S_FETCH);
            S_WB:    w_next = r_wrap ? S_HALT : S_FETCH;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= PC_START;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu     <= '0;
            r_mdr     <= '0;
            r_wrap    <= 1'b0;
            r_result  <= '0;
            r_illegal <= 1'b0;
            r_count   <= '0;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            if (w_start_ok) begin
                r_pc      <= PC_START;
                r_illegal <= 1'b0;
                r_count   <= '0;
                r_result  <= '0;
                for (int i = 0; i < 32; i++) r_regs[i] <= '0;
            end
            case (r_state)
                S_FETCH:  r_ir <= r_imem[r_pc];
                S_DECODE: begin
                    r_a <= r_regs[r_ir[25:21]];
                    r_b <= r_regs[r_ir[20:16]];
                end
                S_EXEC: begin
                    r_pc   <= w_pc_next;
                    r_wrap <= w_wrap_now;
                    if (w_cls == C_ILL) r_illegal <= 1'b1;
                    case (w_cls)
                        C_ADDU:  r_alu <= r_a + r_b;
                        C_SLT:   r_alu <= DATA_W'($signed(r_a) < $signed(r_b));
                        C_JAL:   r_alu <= w_pc1_32[DATA_W-1:0];
                        default: r_alu <= r_a + w_imm;
                    endcase
                end
                S_MEM:   r_mdr <= r_dmem[w_daddr];
                S_WB:    if (w_wa != 5'd0) r_regs[w_wa] <= w_wdata;
                default: ;
            endcase
            if (w_retire && r_count != 16'hFFFF) r_count <= r_count + 16'd1;
            // A final WB into OUT_REG is forwarded so the captured result includes it.
            if (w_next == S_HALT && r_state != S_HALT)
                r_result <= (r_state == S_WB && w_wa == OUT_IDX && OUT_IDX != 5'd0)
                            ? w_wdata : r_regs[OUT_IDX];
        end
    end

    // NOTE: memories carry no reset so they map onto RAM primitives; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (imem_we && !busy) r_imem[imem_addr] <= imem_wdata;
        if (r_state == S_MEM && w_cls == C_SW) r_dmem[w_daddr] <= r_b;
        else if (dmem_we && !busy)            r_dmem[dmem_addr] <= dmem_wdata;
    end

    assign dmem_rdata  = r_dmem[dmem_addr];
    assign busy        = (r_state != S_IDLE) && (r_state != S_HALT);
    assign done        = (r_state == S_HALT);
    assign result      = r_result;
    assign pc          = r_pc;
    assign illegal     = r_illegal;
    assign instr_count = r_count;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: table of small programs with hand-computed
// results and cycle counts, plus mid-run reset, busy-ignore and dmem read-back sequences.
module tb_mips_multicycle_core;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic        imem_we = 1'b0;
    logic [3:0]  imem_addr = '0;
    logic [31:0] imem_wdata = '0;
    logic        dmem_we = 1'b0;
    logic [3:0]  dmem_addr = '0;
    logic [7:0]  dmem_wdata = '0;
    logic [7:0]  dmem_rdata;
    logic        busy, done, illegal;
    logic [7:0]  result;
    logic [3:0]  pc;
    logic [15:0] instr_count;

    mips_multicycle_core dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .busy(busy), .done(done), .result(result),
        .pc(pc), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0][31:0] prog;
        logic [4:0]        n;
        logic              use_dmem;
        logic [7:0]        exp_result;
        logic [15:0]       exp_count;
        logic              exp_illegal;
        logic [3:0]        exp_pc;
        logic [15:0]       exp_cycles;
    } vec_t;

    vec_t              vecs [8];
    string             names [8];
    int                n_vecs = 0;
    int                n_checks = 0;
    int                n_fail = 0;
    logic [15:0][31:0] p;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int funct);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input logic [15:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(input int op, input int target);
        return {6'(op), 26'(target)};
    endfunction

    localparam logic [31:0] HALT_W = {6'd63, 26'd0};

    task automatic add_vec(input string nm, input logic [15:0][31:0] pr, input int n, input bit dm,
                           input int res, input int cnt, input bit ill, input int epc, input int cyc);
        vecs[n_vecs].prog        = pr;
        vecs[n_vecs].n           = 5'(n);
        vecs[n_vecs].use_dmem    = dm;
        vecs[n_vecs].exp_result  = 8'(res);
        vecs[n_vecs].exp_count   = 16'(cnt);
        vecs[n_vecs].exp_illegal = ill;
        vecs[n_vecs].exp_pc      = 4'(epc);
        vecs[n_vecs].exp_cycles  = 16'(cyc);
        names[n_vecs]            = nm;
        n_vecs++;
    endtask

    task automatic load_dmem();
        logic [7:0] vals [7];
        int         addrs [7];
        vals  = '{8'h9C, 8'h8F, 8'h70, 8'h3B, 8'h20, 8'h50, 8'h06};
        addrs = '{0, 1, 2, 3, 4, 5, 10};
        @(negedge clk);
        dmem_we = 1'b1;
        for (int i = 0; i < 7; i++) begin
            dmem_addr  = 4'(addrs[i]);
            dmem_wdata = vals[i];
            @(negedge clk);
        end
        dmem_we = 1'b0;
    endtask

    // Word 0 is written in the same cycle start is raised, so the first fetch must see it.
    task automatic load_and_start(input vec_t v);
        @(negedge clk);
        imem_we = 1'b1;
        for (int i = 1; i < int'(v.n); i++) begin
            imem_addr  = 4'(i);
            imem_wdata = v.prog[i];
            @(negedge clk);
        end
        imem_addr  = 4'd0;
        imem_wdata = v.prog[0];
        start      = 1'b1;
        @(posedge clk);
        #1;
        imem_we = 1'b0;
        start   = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, c2;

        p = '0;
        p[0] = enc_i(35, 0, 4, 16'd10);
        p[1] = enc_j(3, 3);
        p[2] = HALT_W;
        p[3] = enc_i(35, 1, 5, 16'd0);
        p[4] = enc_r(2, 5, 2, 33);
        p[5] = enc_i(9, 1, 1, 16'd1);
        p[6] = enc_r(1, 4, 6, 42);
        p[7] = enc_i(5, 6, 0, 16'hFFFB);
        p[8] = enc_r(31, 0, 0, 8);
        add_vec("array_sum", p, 9, 1'b1, 'h46, 33, 1'b0, 2, 134);

        p = '0;
        p[0] = enc_i(9, 0, 0, 16'd5);
        p[1] = enc_r(0, 0, 2, 33);
        p[2] = HALT_W;
        add_vec("zero_reg", p, 3, 1'b0, 'h00, 2, 1'b0, 2, 10);

        p = '0;
        p[0] = enc_i(9, 0, 1, 16'h0080);
        p[1] = enc_i(9, 0, 3, 16'd1);
        p[2] = enc_r(1, 3, 2, 42);
        p[3] = HALT_W;
        add_vec("slt_neg_lt_pos", p, 4, 1'b0, 'h01, 3, 1'b0, 3, 14);

        p[2] = enc_r(3, 1, 2, 42);
        add_vec("slt_pos_lt_neg", p, 4, 1'b0, 'h00, 3, 1'b0, 3, 14);

        p = '0;
        p[0] = enc_i(9, 0, 1, 16'h005A);
        p[1] = enc_i(43, 0, 1, 16'd3);
        p[2] = enc_i(35, 0, 2, 16'd3);
        p[3] = HALT_W;
        add_vec("store_load", p, 4, 1'b0, 'h5A, 3, 1'b0, 3, 15);

        p = '0;
        p[0] = enc_i(62, 0, 0, 16'd0);
        p[1] = HALT_W;
        add_vec("illegal_op", p, 2, 1'b0, 'h00, 1, 1'b1, 1, 5);

        for (int i = 0; i < 16; i++) p[i] = enc_r(0, 0, 0, 33);
        add_vec("nop_wrap", p, 16, 1'b0, 'h00, 16, 1'b0, 0, 64);

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #20;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset result", result, 8'h00);
        check("reset pc", pc, 4'h0);
        check("reset illegal", illegal, 1'b0);
        check("reset instr_count", instr_count, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < n_vecs; k++) begin
            if (vecs[k].use_dmem) load_dmem();
            load_and_start(vecs[k]);
            check({names[k], " busy after start"}, busy, 1'b1);
            wait_done(cyc);
            check({names[k], " done"}, done, 1'b1);
            check({names[k], " cycles"}, cyc, 32'(vecs[k].exp_cycles));
            check({names[k], " result"}, result, vecs[k].exp_result);
            check({names[k], " instr_count"}, instr_count, vecs[k].exp_count);
            check({names[k], " illegal"}, illegal, vecs[k].exp_illegal);
            check({names[k], " pc"}, pc, vecs[k].exp_pc);
        end

        dmem_addr = 4'd3;
        #1;
        check("dmem_rdata addr3 after sw", dmem_rdata, 8'h5A);

        // Mid-run asynchronous reset, checked before the next clock edge.
        load_dmem();
        load_and_start(vecs[0]);
        repeat (50) @(posedge clk);
        #2;
        check("midrun busy before reset", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrun reset busy", busy, 1'b0);
        check("midrun reset done", done, 1'b0);
        check("midrun reset result", result, 8'h00);
        check("midrun reset pc", pc, 4'h0);
        check("midrun reset instr_count", instr_count, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Re-run from preserved memories; start and imem write while busy must be ignored.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        start      = 1'b1;
        imem_we    = 1'b1;
        imem_addr  = 4'd2;
        imem_wdata = 32'h0000_0000;
        @(posedge clk);
        #1;
        start   = 1'b0;
        imem_we = 1'b0;
        cyc++;
        wait_done(c2);
        cyc += c2;
        check("rerun done", done, 1'b1);
        check("rerun cycles", cyc, 134);
        check("rerun result", result, 8'h46);
        check("rerun instr_count", instr_count, 16'd33);
        check("rerun illegal", illegal, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
